// File: rtl/counter_pkg.sv
// Shared definitions for consumers of the 3-bit counter output code {Q1, Q0, Q1|Q0}.
package counter_pkg;

  localparam logic [2:0] CODE_0 = 3'b000;
  localparam logic [2:0] CODE_1 = 3'b011;
  localparam logic [2:0] CODE_2 = 3'b101;
  localparam logic [2:0] CODE_3 = 3'b111;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] count;
  } decode_t;

  function automatic decode_t decode_code(input logic [2:0] code);
    decode_t d;
    d = '{legal: 1'b1, count: 2'd0};
    case (code)
      CODE_0:  d.count = 2'd0;
      CODE_1:  d.count = 2'd1;
      CODE_2:  d.count = 2'd2;
      CODE_3:  d.count = 2'd3;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/counter_code_decode.sv
// Combinational decoder: received counter code -> legal flag and 2-bit count.
module counter_code_decode
  import counter_pkg::*;
(
  input  logic [2:0] code,
  output logic       legal,
  output logic [1:0] count
);

  decode_t dec;

  always_comb begin
    dec   = decode_code(code);
    legal = dec.legal;
    count = dec.count;
  end

endmodule

// File: rtl/counter_seq_checker.sv
// Sequence monitor for the mod-4 counter code: acquires lock on the increment
// sequence, flags illegal codes and out-of-sequence steps, counts wraps and errors.
module counter_seq_checker
  import counter_pkg::*;
#(
  parameter int LOCK_N   = 2,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_valid,
  input  logic [2:0]       y_in,
  output logic [1:0]       count_out,
  output logic             locked,
  output logic             code_ill,
  output logic             seq_err,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam int BAD_W  = $clog2(UNLOCK_N + 1);

  state_t            state_reg, state_next;
  logic [1:0]        ref_reg, ref_next;
  logic [GOOD_W-1:0] good_reg, good_next, good_inc;
  logic [BAD_W-1:0]  bad_reg, bad_next, bad_inc;
  logic [1:0]        count_reg, count_next;
  logic              locked_reg;
  logic              ill_reg, ill_next;
  logic              serr_reg, serr_next;
  logic [CNT_W-1:0]  wrap_reg, wrap_next;
  logic [CNT_W-1:0]  err_reg, err_next;

  logic              dec_legal;
  logic [1:0]        dec_count;
  logic [1:0]        exp_cnt;

  counter_code_decode u_decode (
    .code  (y_in),
    .legal (dec_legal),
    .count (dec_count)
  );

  assign exp_cnt  = ref_reg + 2'd1;
  assign good_inc = good_reg + GOOD_W'(1);
  assign bad_inc  = bad_reg + BAD_W'(1);

  always_comb begin
    state_next = state_reg;
    ref_next   = ref_reg;
    good_next  = good_reg;
    bad_next   = bad_reg;
    count_next = count_reg;
    ill_next   = 1'b0;
    serr_next  = 1'b0;
    wrap_next  = wrap_reg;
    err_next   = err_reg;

    if (y_valid) begin
      if (dec_legal) count_next = dec_count;

      unique case (state_reg)
        HUNT: begin
          if (dec_legal) begin
            ref_next   = dec_count;
            good_next  = '0;
            state_next = ACQ;
          end else begin
            ill_next = 1'b1;
          end
        end

        ACQ: begin
          if (!dec_legal) begin
            ill_next   = 1'b1;
            state_next = HUNT;
          end else if (dec_count == exp_cnt) begin
            ref_next  = dec_count;
            good_next = good_inc;
            if (good_inc == GOOD_W'(LOCK_N)) begin
              state_next = LOCK;
              bad_next   = '0;
            end
          end else begin
            ref_next  = dec_count;
            good_next = '0;
          end
        end

        LOCK: begin
          if (dec_legal && (dec_count == exp_cnt)) begin
            ref_next = dec_count;
            bad_next = '0;
            if ((dec_count == 2'd0) && (wrap_reg != '1)) wrap_next = wrap_reg + CNT_W'(1);
          end else begin
            serr_next = 1'b1;
            ill_next  = !dec_legal;
            // An illegal code carries no count, so flywheel on the expected value.
            ref_next  = dec_legal ? dec_count : exp_cnt;
            if (err_reg != '1) err_next = err_reg + CNT_W'(1);
            bad_next  = bad_inc;
            if (bad_inc == BAD_W'(UNLOCK_N)) state_next = HUNT;
          end
        end

        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= HUNT;
      ref_reg    <= '0;
      good_reg   <= '0;
      bad_reg    <= '0;
      count_reg  <= '0;
      locked_reg <= 1'b0;
      ill_reg    <= 1'b0;
      serr_reg   <= 1'b0;
      wrap_reg   <= '0;
      err_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ref_reg    <= ref_next;
      good_reg   <= good_next;
      bad_reg    <= bad_next;
      count_reg  <= count_next;
      locked_reg <= (state_next == LOCK);
      ill_reg    <= ill_next;
      serr_reg   <= serr_next;
      wrap_reg   <= wrap_next;
      err_reg    <= err_next;
    end
  end

  assign count_out = count_reg;
  assign locked    = locked_reg;
  assign code_ill  = ill_reg;
  assign seq_err   = serr_reg;
  assign wrap_cnt  = wrap_reg;
  assign err_cnt   = err_reg;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench: two checker instances (default and CNT_W=2/UNLOCK_N=8) driven by the same stream,
// compared every cycle against a rule-level reference model.
module tb_counter_seq_checker;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       y_valid = 1'b0;
  logic [2:0] y_in = 3'b000;

  logic [1:0] a_count, b_count;
  logic       a_locked, b_locked, a_ill, b_ill, a_serr, b_serr;
  logic [7:0] a_wrap, a_err;
  logic [1:0] b_wrap, b_err;

  int n_assert = 0;
  int n_fail   = 0;
  int n_tx     = 0;

  always #5 clk = ~clk;

  counter_seq_checker dut_a (
    .clk(clk), .rst(rst), .y_valid(y_valid), .y_in(y_in),
    .count_out(a_count), .locked(a_locked), .code_ill(a_ill), .seq_err(a_serr),
    .wrap_cnt(a_wrap), .err_cnt(a_err)
  );

  counter_seq_checker #(.LOCK_N(2), .UNLOCK_N(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .y_valid(y_valid), .y_in(y_in),
    .count_out(b_count), .locked(b_locked), .code_ill(b_ill), .seq_err(b_serr),
    .wrap_cnt(b_wrap), .err_cnt(b_err)
  );

  typedef struct {
    state_t st;
    int     rf;
    int     good;
    int     bad;
    int     cnt;
    bit     lk;
    bit     ill;
    bit     serr;
    int     wrap;
    int     err;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = HUNT; m.rf = 0; m.good = 0; m.bad = 0; m.cnt = 0;
    m.lk = 0; m.ill = 0; m.serr = 0; m.wrap = 0; m.err = 0;
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, bit v, logic [2:0] y, int lockn, int unlockn, int maxc);
    mdl_t n;
    bit   legal;
    int   val;
    int   expv;
    n = m;
    n.ill = 0;
    n.serr = 0;
    if (!v) return n;
    legal = 1;
    val = 0;
    if (y == 3'b000) val = 0;
    else if (y == 3'b011) val = 1;
    else if (y == 3'b101) val = 2;
    else if (y == 3'b111) val = 3;
    else legal = 0;
    expv = (m.rf + 1) % 4;
    if (legal) n.cnt = val;
    if (m.st == HUNT) begin
      if (legal) begin n.rf = val; n.good = 0; n.st = ACQ; end
      else n.ill = 1;
    end else if (m.st == ACQ) begin
      if (!legal) begin n.ill = 1; n.st = HUNT; end
      else if (val == expv) begin
        n.rf = val; n.good = m.good + 1;
        if (n.good == lockn) begin n.st = LOCK; n.bad = 0; end
      end else begin n.rf = val; n.good = 0; end
    end else begin
      if (legal && val == expv) begin
        if (val == 0 && m.wrap < maxc) n.wrap = m.wrap + 1;
        n.rf = val; n.bad = 0;
      end else begin
        n.serr = 1;
        n.ill = !legal;
        if (m.err < maxc) n.err = m.err + 1;
        n.bad = m.bad + 1;
        n.rf = legal ? val : expv;
        if (n.bad == unlockn) n.st = HUNT;
      end
    end
    n.lk = (n.st == LOCK);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s (tx %0d): observed=%0d expected=%0d", tag, n_tx, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/a.count_out"}, 32'(a_count), 32'(ma.cnt));
    chk({tag, "/a.locked"},    32'(a_locked), 32'(ma.lk));
    chk({tag, "/a.code_ill"},  32'(a_ill), 32'(ma.ill));
    chk({tag, "/a.seq_err"},   32'(a_serr), 32'(ma.serr));
    chk({tag, "/a.wrap_cnt"},  32'(a_wrap), 32'(ma.wrap));
    chk({tag, "/a.err_cnt"},   32'(a_err), 32'(ma.err));
    chk({tag, "/a.state"},     32'(dut_a.state_reg), 32'(ma.st));
    chk({tag, "/b.count_out"}, 32'(b_count), 32'(mb.cnt));
    chk({tag, "/b.locked"},    32'(b_locked), 32'(mb.lk));
    chk({tag, "/b.code_ill"},  32'(b_ill), 32'(mb.ill));
    chk({tag, "/b.seq_err"},   32'(b_serr), 32'(mb.serr));
    chk({tag, "/b.wrap_cnt"},  32'(b_wrap), 32'(mb.wrap));
    chk({tag, "/b.err_cnt"},   32'(b_err), 32'(mb.err));
  endtask

  task automatic cycle(input bit v, input logic [2:0] y, input string tag);
    @(negedge clk);
    y_valid = v;
    y_in    = y;
    @(posedge clk);
    #1;
    ma = step(ma, v, y, 2, 2, 255);
    mb = step(mb, v, y, 2, 8, 3);
    n_tx++;
    $display("tx %0d %s v=%b y=%b | a: cnt=%0d lk=%b ill=%b serr=%b wrap=%0d err=%0d | b: cnt=%0d lk=%b ill=%b serr=%b wrap=%0d err=%0d",
             n_tx, tag, v, y, a_count, a_locked, a_ill, a_serr, a_wrap, a_err,
             b_count, b_locked, b_ill, b_serr, b_wrap, b_err);
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] codes [4];
    int seq;
    codes[0] = 3'b000; codes[1] = 3'b011; codes[2] = 3'b101; codes[3] = 3'b111;
    ma = mdl_reset();
    mb = mdl_reset();

    // Power-on reset
    #1;
    check_all("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clean sequence, lock after 2nd correct step, wrap on 111->000
    for (int i = 0; i < 9; i++) cycle(1'b1, codes[i % 4], "clean");

    // Single illegal code while locked: flywheel keeps lock
    cycle(1'b1, 3'b110, "inject_ill");
    cycle(1'b1, codes[2], "resume");
    cycle(1'b1, codes[3], "resume");
    cycle(1'b1, codes[0], "resume");

    // Two consecutive mismatches: A drops lock, B holds
    cycle(1'b1, codes[1], "mm_pre");
    cycle(1'b1, codes[1], "mm1");
    cycle(1'b1, codes[1], "mm2");

    // Acquisition with a skip, then realign and lock
    cycle(1'b1, codes[0], "acq");
    cycle(1'b1, codes[2], "acq_skip");
    cycle(1'b1, codes[3], "acq");
    cycle(1'b1, codes[0], "acq_lock");

    // Error bursts with y_valid gaps in between
    cycle(1'b1, codes[1], "gap_pre");
    cycle(1'b0, 3'b010, "gap");
    cycle(1'b1, 3'b100, "err");
    cycle(1'b0, 3'b111, "gap");
    cycle(1'b0, 3'b001, "gap");
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'b001, "sat_err");
    cycle(1'b0, 3'b000, "gap");

    // Reset pulse mid-cycle with y_valid high on 011
    @(negedge clk);
    y_valid = 1'b1;
    y_in    = 3'b011;
    #2 rst = 1'b1;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ma = step(ma, 1'b1, 3'b011, 2, 2, 255);
    mb = step(mb, 1'b1, 3'b011, 2, 8, 3);
    n_tx++;
    $display("tx %0d rst_release a: cnt=%0d lk=%b b: cnt=%0d lk=%b", n_tx, a_count, a_locked, b_count, b_locked);
    check_all("rst_release");
    chk("rst_release/count_is_1", 32'(a_count), 32'd1);

    // Randomized stream, mostly in sequence with occasional repeats and random codes
    seq = 2;
    for (int i = 0; i < 300; i++) begin
      int  r;
      bit  v;
      logic [2:0] y;
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      if (r < 7) begin
        y = codes[seq];
        seq = (seq + 1) % 4;
      end else if (r < 8) begin
        y = codes[(seq + 3) % 4];
      end else begin
        y = 3'($urandom_range(0, 7));
      end
      cycle(v, y, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
